result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/mm_pkg.sv | 31 +++
 rtl/res_fifo.sv | 50 +++++
 rtl/result_collector.sv | 140 ++++++++++++++
 tb/tb_result_collector.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types for the result collector: dimension width, FSM states and buffer entry layout.
package mm_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int DIM_W      = 2;
  localparam int CNT_W      = 2 * DIM_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } tag_t;

  // Buffer entry at the default element width; wider builds pack {data, tag} the same way.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    tag_t                  tag;
  } entry_t;

  function automatic logic is_last(input tag_t t, input logic [DIM_W-1:0] rw,
                                   input logic [DIM_W-1:0] cx);
    return (t.row == rw - DIM_W'(1)) && (t.col == cx - DIM_W'(1));
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Circular buffer of DEPTH entries (any DEPTH >= 1) with full/empty and same-cycle push/pop.
module res_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_do_push, w_do_pop;

  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_data   = r_mem[r_rd];

  // Storage needs no reset: reads are only meaningful while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_do_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/result_collector.sv
// Tags a row-major result stream with (row, col), buffers it and hands it downstream.
// Optional running maximum of accepted elements: define RESULT_MAX_TRACK_EN.
module result_collector
  import mm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clear_mem_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  row_w,
  input  logic [DIM_W-1:0]  col_x,
  input  logic [DATA_W-1:0] res_in,
  input  logic              res_in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef RESULT_MAX_TRACK_EN
  ,
  output logic [DATA_W-1:0] res_max
`endif
);
  localparam int ENT_W = DATA_W + 2 * DIM_W;

  state_e           r_state;
  logic [DIM_W-1:0] r_row_w, r_col_x, r_row, r_col;
  logic [CNT_W-1:0] r_expected, r_count;
  logic             r_busy, r_done, r_overflow;
  logic             w_full, w_empty, w_pop, w_push, w_drop, w_start_ok, w_last;
  logic [ENT_W-1:0] w_wr_ent, w_rd_ent;
  tag_t             w_rd_tag;

  assign w_pop      = !w_empty && out_ready;
  assign w_push     = (r_state == ST_COLLECT) && res_in_valid && (!w_full || w_pop);
  assign w_drop     = (r_state == ST_COLLECT) && res_in_valid && w_full && !w_pop;
  assign w_start_ok = (r_state == ST_IDLE) && start && (row_w != '0) && (col_x != '0);
  assign w_wr_ent   = {res_in, r_row, r_col};
  assign w_rd_tag   = tag_t'(w_rd_ent[2*DIM_W-1:0]);
  assign w_last     = !w_empty && is_last(w_rd_tag, r_row_w, r_col_x);

  res_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clr_n   (clear_mem_n),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (w_wr_ent),
    .rd_data (w_rd_ent),
    .full    (w_full),
    .empty   (w_empty)
  );

  // An empty buffer presents all-zero data and tags.
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rd_ent[ENT_W-1:2*DIM_W];
  assign out_row   = w_empty ? '0 : w_rd_tag.row;
  assign out_col   = w_empty ? '0 : w_rd_tag.col;
  assign out_last  = w_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (!clear_mem_n) begin
      r_state    <= ST_IDLE;
      r_row_w    <= '0;
      r_col_x    <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_expected <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_row_w    <= row_w;
            r_col_x    <= col_x;
            r_expected <= CNT_W'(row_w) * CNT_W'(col_x);
            r_count    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_drop) r_overflow <= 1'b1;
          // Only accepted elements advance the tags and the job count.
          if (w_push) begin
            r_count <= r_count + CNT_W'(1);
            if (r_col == r_col_x - DIM_W'(1)) begin
              r_col <= '0;
              r_row <= r_row + DIM_W'(1);
            end else begin
              r_col <= r_col + DIM_W'(1);
            end
            if (r_count + CNT_W'(1) == r_expected) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RESULT_MAX_TRACK_EN
  logic [DATA_W-1:0] r_res_max;

  always_ff @(posedge clk) begin
    if (!clear_mem_n) r_res_max <= '0;
    else if (w_start_ok) r_res_max <= '0;
    else if (w_push && (res_in > r_res_max)) r_res_max <= res_in;
    else r_res_max <= r_res_max;
  end

  assign res_max = r_res_max;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed job scenarios plus a randomized
// run against a queue-based reference model.
module tb_result_collector;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              clear_mem_n, start, res_in_valid, out_ready;
  logic [1:0]        row_w, col_x;
  logic [DATA_W-1:0] res_in;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_row, out_col;
  logic              out_valid, out_last, busy, done, overflow;
`ifdef RESULT_MAX_TRACK_EN
  logic [DATA_W-1:0] res_max;
`endif

  int n_total = 0;
  int n_pass  = 0;

  result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
`ifdef RESULT_MAX_TRACK_EN
    .res_max      (res_max),
`endif
    .clear_mem_n  (clear_mem_n),
    .start        (start),
    .row_w        (row_w),
    .col_x        (col_x),
    .res_in       (res_in),
    .res_in_valid (res_in_valid),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Collected downstream handshakes of the last directed stream.
  int g_d[$], g_r[$], g_c[$], g_l[$];
  int g_done_n, g_done_at, g_last_at, g_first_at, g_ovf_at_done, g_max_at_done;

  // Reference model: queue of outputs plus job bookkeeping.
  typedef struct { int data; int row; int col; int idx; } ment_t;
  ment_t mq[$];
  int    m_exp, m_acc, m_cx;
  bit    m_active, m_done, m_ovf;

  task automatic model_edge(input bit rn, input bit st, input int rw, input int cx,
                            input bit v, input int d, input bit rdy);
    bit pop, last_pop, push_att, done_prev;
    if (!rn) begin
      mq.delete(); m_active = 0; m_done = 0; m_ovf = 0; m_acc = 0; m_exp = 0; m_cx = 1;
      return;
    end
    done_prev = m_done;
    pop       = (mq.size() > 0) && rdy;
    last_pop  = pop && (mq[0].idx == m_exp - 1);
    push_att  = m_active && (m_acc < m_exp) && v;
    if (push_att && (mq.size() < DEPTH || pop)) begin
      mq.push_back('{d, m_acc / m_cx, m_acc % m_cx, m_acc});
      m_acc++;
    end else if (push_att) begin
      m_ovf = 1;
    end
    if (pop) void'(mq.pop_front());
    m_done = 0;
    if (last_pop) begin m_active = 0; m_done = 1; end
    if (!m_active && !done_prev && !last_pop && st && rw != 0 && cx != 0) begin
      m_active = 1; m_acc = 0; m_exp = rw * cx; m_cx = cx; m_ovf = 0;
    end
  endtask

  task automatic do_reset();
    clear_mem_n = 1'b0; start = 1'b0; res_in_valid = 1'b0; res_in = '0;
    row_w = 2'd0; col_x = 2'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    clear_mem_n = 1'b1;
  endtask

  // Starts a job and streams vals back-to-back; out_ready is low for cycles < ready_after.
  // A start with 1x1 dims is injected at cycle start_at (negative: never).
  task automatic run_stream(input int rw, input int cx, input int vals[$],
                            input int ready_after, input int start_at);
    start = 1'b1; row_w = 2'(rw); col_x = 2'(cx); res_in_valid = 1'b0;
    out_ready = (ready_after == 0);
    @(posedge clk); #1;
    start = 1'b0;
    g_d.delete(); g_r.delete(); g_c.delete(); g_l.delete();
    g_done_n = 0; g_done_at = -1; g_last_at = -1; g_first_at = -1;
    g_ovf_at_done = -1; g_max_at_done = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      res_in_valid = (cyc < vals.size());
      res_in       = (cyc < vals.size()) ? DATA_W'(vals[cyc]) : '0;
      out_ready    = (cyc >= ready_after);
      start        = (cyc == start_at);
      row_w        = (cyc == start_at) ? 2'd1 : 2'(rw);
      col_x        = (cyc == start_at) ? 2'd1 : 2'(cx);
      @(negedge clk);
      if (out_valid && g_first_at < 0) g_first_at = cyc;
      if (out_valid && out_ready) begin
        g_d.push_back(int'(out_data)); g_r.push_back(int'(out_row));
        g_c.push_back(int'(out_col));  g_l.push_back(int'(out_last));
        if (out_last) g_last_at = cyc;
      end
      if (done) begin
        g_done_n++; g_done_at = cyc; g_ovf_at_done = int'(overflow);
`ifdef RESULT_MAX_TRACK_EN
        g_max_at_done = int'(res_max);
`endif
      end
      @(posedge clk); #1;
    end
    res_in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem_n = 1'b0; start = 1'b1; row_w = 2'd3; col_x = 2'd3;
    res_in_valid = 1'b1; res_in = 10'd77; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_last, busy, done, overflow} !== 5'b0 || out_data !== '0 ||
        out_row !== '0 || out_col !== '0)
      $display("FAIL reset_outputs: got v%0b l%0b b%0b d%0b o%0b data%0d expected all 0",
               out_valid, out_last, busy, done, overflow, out_data);
    else n_pass++;
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_basic();
    int vals[$] = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
    do_reset();
    run_stream(3, 3, vals, 0, -1);
    n_total++;
    if (g_d.size() !== 9) $display("FAIL basic_count: got %0d expected 9", g_d.size());
    else begin
      n_pass++;
      for (int i = 0; i < 9; i++) begin
        n_total++;
        if (g_d[i] !== vals[i] || g_r[i] !== i / 3 || g_c[i] !== i % 3 || g_l[i] !== int'(i == 8))
          $display("FAIL basic_elem%0d: got d%0d r%0d c%0d l%0d expected d%0d r%0d c%0d l%0d",
                   i, g_d[i], g_r[i], g_c[i], g_l[i], vals[i], i / 3, i % 3, int'(i == 8));
        else n_pass++;
      end
    end
    n_total++;
    if (g_first_at !== 1) $display("FAIL basic_latency: got %0d expected 1", g_first_at);
    else n_pass++;
    n_total++;
    if (g_done_n !== 1 || g_done_at !== g_last_at + 1)
      $display("FAIL basic_done: got pulses %0d at %0d expected 1 at %0d",
               g_done_n, g_done_at, g_last_at + 1);
    else n_pass++;
`ifdef RESULT_MAX_TRACK_EN
    n_total++;
    if (g_max_at_done !== 151) $display("FAIL res_max: got %0d expected 151", g_max_at_done);
    else n_pass++;
`endif
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %0b expected 0", busy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int vals[$] = '{41, 45, 49, 87, 96, 105, 125, 138, 151, 160};
    int expd[$] = '{41, 45, 49, 87, 105, 125, 138, 151, 160};
    do_reset();
    run_stream(3, 3, vals, 5, -1);
    n_total++;
    if (g_d.size() !== 9) $display("FAIL ovf_count: got %0d expected 9", g_d.size());
    else begin
      n_pass++;
      for (int i = 0; i < 9; i++) begin
        n_total++;
        if (g_d[i] !== expd[i] || g_r[i] !== i / 3 || g_c[i] !== i % 3 || g_l[i] !== int'(i == 8))
          $display("FAIL ovf_elem%0d: got d%0d r%0d c%0d l%0d expected d%0d r%0d c%0d l%0d",
                   i, g_d[i], g_r[i], g_c[i], g_l[i], expd[i], i / 3, i % 3, int'(i == 8));
        else n_pass++;
      end
    end
    n_total++;
    if (g_done_n !== 1 || g_ovf_at_done !== 1)
      $display("FAIL ovf_done_flag: got pulses %0d ovf %0d expected 1 and 1", g_done_n, g_ovf_at_done);
    else n_pass++;
  endtask

  task automatic test_one_by_one();
    int vals[$] = '{150};
    do_reset();
    run_stream(1, 1, vals, 0, -1);
    n_total++;
    if (g_d.size() !== 1 || g_d[0] !== 150 || g_r[0] !== 0 || g_c[0] !== 0 || g_l[0] !== 1)
      $display("FAIL one_by_one: got n%0d d%0d expected n1 d150 r0 c0 last1",
               g_d.size(), (g_d.size() > 0) ? g_d[0] : -1);
    else n_pass++;
    n_total++;
    if (g_done_n !== 1) $display("FAIL one_by_one_done: got %0d expected 1", g_done_n);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    int vals[$] = '{11, 22, 33, 44};
    do_reset();
    start = 1'b1; row_w = 2'd0; col_x = 2'd2;
    @(posedge clk); #1;
    start = 1'b0; res_in_valid = 1'b1; res_in = 10'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL zero_dim_start: got busy %0b valid %0b expected 0 0", busy, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    res_in_valid = 1'b0;
    run_stream(2, 2, vals, 0, 2);
    n_total++;
    if (g_d.size() !== 4 || g_r[3] !== 1 || g_c[3] !== 1 || g_l[3] !== 1 || g_l[1] !== 0 ||
        g_c[2] !== 0 || g_d[3] !== 44)
      $display("FAIL midjob_start: got n%0d expected 4 elements tagged (0,0)..(1,1)", g_d.size());
    else n_pass++;
    n_total++;
    if (g_done_n !== 1) $display("FAIL midjob_start_done: got %0d expected 1", g_done_n);
    else n_pass++;
  endtask

  task automatic test_midjob_reset();
    int vals[$] = '{7, 9};
    int dn = 0;
    do_reset();
    start = 1'b1; row_w = 2'd3; col_x = 2'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_in_valid = 1'b1; res_in = DATA_W'(100 + i);
      @(posedge clk); #1;
    end
    res_in_valid = 1'b0; clear_mem_n = 1'b0;
    @(posedge clk); #1;
    clear_mem_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_last, busy, done, overflow} !== 5'b0 || out_data !== '0 ||
        out_row !== '0 || out_col !== '0)
      $display("FAIL midjob_reset_outputs: got v%0b l%0b b%0b d%0b o%0b expected all 0",
               out_valid, out_last, busy, done, overflow);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || out_valid) dn++;
    end
    n_total++;
    if (dn !== 0) $display("FAIL midjob_reset_quiet: got %0d active cycles expected 0", dn);
    else n_pass++;
    @(posedge clk); #1;
    run_stream(1, 2, vals, 0, -1);
    n_total++;
    if (g_d.size() !== 2 || g_d[0] !== 7 || g_d[1] !== 9 || g_c[1] !== 1 || g_l[1] !== 1 ||
        g_done_n !== 1)
      $display("FAIL after_reset_job: got n%0d done %0d expected n2 done 1", g_d.size(), g_done_n);
    else n_pass++;
  endtask

  task automatic test_random();
    bit st, v, rdy, rn;
    int rw, cx, d;
    bit e_valid;
    int e_data, e_row, e_col, e_last;
    do_reset();
    model_edge(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rn  = ($urandom_range(0, 249) != 0);
      st  = ($urandom_range(0, 7) == 0);
      rw  = $urandom_range(0, 3);
      cx  = $urandom_range(0, 3);
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 5);
      d   = $urandom_range(0, 1023);
      clear_mem_n = rn; start = st; row_w = 2'(rw); col_x = 2'(cx);
      res_in_valid = v; res_in = DATA_W'(d); out_ready = rdy;
      e_valid = (mq.size() > 0);
      e_data  = e_valid ? mq[0].data : 0;
      e_row   = e_valid ? mq[0].row : 0;
      e_col   = e_valid ? mq[0].col : 0;
      e_last  = e_valid ? int'(mq[0].idx == m_exp - 1) : 0;
      @(negedge clk);
      n_total++;
      if (out_valid !== e_valid) $display("FAIL rnd_valid c%0d: got %0b expected %0b", cyc, out_valid, e_valid);
      else n_pass++;
      n_total++;
      if (int'(out_data) !== e_data) $display("FAIL rnd_data c%0d: got %0d expected %0d", cyc, out_data, e_data);
      else n_pass++;
      n_total++;
      if (int'(out_row) !== e_row || int'(out_col) !== e_col)
        $display("FAIL rnd_tag c%0d: got (%0d,%0d) expected (%0d,%0d)", cyc, out_row, out_col, e_row, e_col);
      else n_pass++;
      n_total++;
      if (int'(out_last) !== e_last) $display("FAIL rnd_last c%0d: got %0b expected %0d", cyc, out_last, e_last);
      else n_pass++;
      n_total++;
      if (busy !== m_active || done !== m_done || overflow !== m_ovf)
        $display("FAIL rnd_status c%0d: got b%0b d%0b o%0b expected b%0b d%0b o%0b",
                 cyc, busy, done, overflow, m_active, m_done, m_ovf);
      else n_pass++;
      @(posedge clk);
      model_edge(rn, st, rw, cx, v, d, rdy);
      #1;
    end
    clear_mem_n = 1'b1; start = 1'b0; res_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_one_by_one();
    test_ignored_start();
    test_midjob_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
